// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding load/store engine between a valid/ready
// request port and a 64-bit doubleword data memory with a combinational read.
// Loads take ACCESS -> RESP; double stores take WRITE -> RESP; narrower stores
// read-modify-write through ACCESS -> WRITE -> RESP. Out-of-range or faulting
// requests go straight from IDLE to RESP with resp_err set.
// Optional feature macro: LSU_MISALIGN_TRAP_EN. When defined, misaligned
// accesses fault; when undefined, the address is force-aligned to the size.
module load_store_unit #(
  parameter int MEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  // Latched request and response fields
  logic        r_we;
  logic [1:0]  r_size;
  logic        r_unsigned;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic [63:0] r_resp_rdata;
  logic        r_resp_err;

  // Request decode
  logic [2:0]  w_align_mask;
  logic        w_oor;
  logic        w_misalign;
  logic        w_req_err;
  logic [63:0] w_addr_eff;

  // Datapath helpers
  logic [63:0] w_lanes;
  logic [63:0] w_load_ext;
  logic [7:0]  w_size_mask;
  logic [7:0]  w_byte_mask;
  logic [63:0] w_shift_wdata;
  logic [63:0] w_merged;

  // Low address bits that must be zero for the requested access size
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    w_align_mask = 3'b000;
    case (req_size)
      2'b00:   w_align_mask = 3'b000;
      2'b01:   w_align_mask = 3'b001;
      2'b10:   w_align_mask = 3'b011;
      default: w_align_mask = 3'b111;
    endcase
  end

  assign w_oor = (req_addr[63:3] >= 61'(MEM_DEPTH));

`ifdef LSU_MISALIGN_TRAP_EN
  assign w_misalign = |(req_addr[2:0] & w_align_mask);
  assign w_addr_eff = req_addr;
`else
  assign w_misalign = 1'b0;
  assign w_addr_eff = {req_addr[63:3], req_addr[2:0] & ~w_align_mask};
`endif

  assign w_req_err = w_oor | w_misalign;

  // Load path: shift the addressed lanes down and extend to 64 bits
  assign w_lanes = mem_rdata >> {r_addr[2:0], 3'b000};

  always_comb begin
    w_load_ext = w_lanes;
    case (r_size)
      2'b00:   w_load_ext = r_unsigned ? {56'd0, w_lanes[7:0]}
                                       : {{56{w_lanes[7]}}, w_lanes[7:0]};
      2'b01:   w_load_ext = r_unsigned ? {48'd0, w_lanes[15:0]}
                                       : {{48{w_lanes[15]}}, w_lanes[15:0]};
      2'b10:   w_load_ext = r_unsigned ? {32'd0, w_lanes[31:0]}
                                       : {{32{w_lanes[31]}}, w_lanes[31:0]};
      default: w_load_ext = w_lanes;
    endcase
  end

  // Store path: replace only the addressed bytes of the sampled doubleword
  always_comb begin
    w_size_mask = 8'hFF;
    case (r_size)
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  assign w_byte_mask   = w_size_mask << r_addr[2:0];
  assign w_shift_wdata = r_wdata << {r_addr[2:0], 3'b000};

  // Byte-lane merge; a double store has every lane selected, so the stale
  // sample never leaks through on the direct WRITE path
  always_comb begin
    w_merged = r_rdata;
    for (int i = 0; i < 8; i++) begin
      if (w_byte_mask[i]) w_merged[8*i +: 8] = w_shift_wdata[8*i +: 8];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Next-state and control outputs; strobes are gated by rst_n so a reset
  // landing in ACCESS/WRITE never completes a memory access
  always_comb begin
    w_next     = r_state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_req_err)                      w_next = RESP;
          else if (req_we && req_size == 2'b11) w_next = WRITE;
          else                                w_next = ACCESS;
        end
      end
      ACCESS: begin
        mem_read = rst_n;
        w_next   = r_we ? WRITE : RESP;
      end
      WRITE: begin
        mem_write = rst_n;
        w_next    = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request latch, memory sample and response registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we         <= 1'b0;
      r_size       <= 2'b00;
      r_unsigned   <= 1'b0;
      r_addr       <= 64'd0;
      r_wdata      <= 64'd0;
      r_rdata      <= 64'd0;
      r_resp_rdata <= 64'd0;
      r_resp_err   <= 1'b0;
    end else begin
      if (r_state == IDLE && req_valid) begin
        r_we         <= req_we;
        r_size       <= req_size;
        r_unsigned   <= req_unsigned;
        r_addr       <= w_addr_eff;
        r_wdata      <= req_wdata;
        r_resp_rdata <= 64'd0;
        r_resp_err   <= w_req_err;
      end
      if (r_state == ACCESS) begin
        r_rdata <= mem_rdata;
        if (!r_we) r_resp_rdata <= w_load_ext;
      end
    end
  end

  assign mem_addr   = {3'b000, r_addr[63:3]};
  assign mem_wdata  = mem_write ? w_merged : 64'd0;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vector table plus randomized traffic checked
// against a byte-addressed reference memory, with reset and hold corner cases.
module tb_load_store_unit;

  localparam int MEM_DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;

  int total = 0;
  int bad   = 0;
  int proto_err = 0;

  load_store_unit #(.MEM_DEPTH(MEM_DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  always #5 clk = ~clk;

  // Attached data memory: combinational read, write on the rising edge
  logic [63:0] tb_mem [0:MEM_DEPTH-1];
  assign mem_rdata = tb_mem[mem_addr[5:0]];
  always @(posedge clk) if (mem_write) tb_mem[mem_addr[5:0]] <= mem_wdata;

  // Reference memory kept as bytes
  logic [7:0] ref_mem [0:MEM_DEPTH*8-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model of one access, from the byte-level rules
  function automatic void ref_access(input logic we, input logic [1:0] sz, input logic uns,
                                     input logic [63:0] addr, input logic [63:0] wd,
                                     output logic [63:0] rdata, output logic err,
                                     output int lat, output int nrd, output int nwr,
                                     output logic [63:0] widx);
    int nbytes;
    logic [63:0] ea;
    logic mis;
    logic [63:0] val;
    nbytes = 1 << sz;
    ea = addr;
    mis = (addr % 64'(nbytes)) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = mis;
`else
    err = 1'b0;
    ea = addr - (addr % 64'(nbytes));
`endif
    if ((addr >> 3) >= 64'(MEM_DEPTH)) err = 1'b1;
    rdata = 64'd0;
    widx = ea >> 3;
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
      return;
    end
    if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[int'(ea) + i] = wd[8*i +: 8];
      lat = (nbytes == 8) ? 2 : 3;
      nrd = (nbytes == 8) ? 0 : 1;
      nwr = 1;
    end else begin
      val = 64'd0;
      for (int i = 0; i < nbytes; i++) val[8*i +: 8] = ref_mem[int'(ea) + i];
      if (!uns && nbytes < 8 && val[8*nbytes-1]) val = val | ~((64'd1 << (8*nbytes)) - 64'd1);
      rdata = val;
      lat = 2; nrd = 1; nwr = 0;
    end
  endfunction

  // Issue one request, scramble req_* after accept, collect the response
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd, input int hold,
                        output logic [63:0] rdata, output logic err, output int lat,
                        output int nrd, output int nwr, output logic [63:0] waddr);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!req_ready) check("accept_timeout", {63'd0, req_ready}, 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    lat = 0; nrd = 0; nwr = 0; waddr = 64'd0;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++;
        waddr = mem_addr;
      end
      if (mem_read && mem_write) proto_err++;
      if (!mem_write && mem_wdata != 64'd0) proto_err++;
      if (req_ready) proto_err++;
      if (resp_valid) break;
    end
    if (!resp_valid) check("resp_timeout", {63'd0, resp_valid}, 64'd1);
    rdata = resp_rdata;
    err = resp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, resp_valid}, 64'd1);
      check("hold_rdata", resp_rdata, rdata);
      check("hold_err", {63'd0, resp_err}, {63'd0, err});
      check("hold_ready", {63'd0, req_ready}, 64'd0);
      if (mem_read || mem_write) proto_err++;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wd;
    int          hold;
    logic [63:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_nrd;
    int          exp_nwr;
    logic [63:0] exp_w2;
  } vec_t;

  vec_t vecs [0:12];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] rd, e_rd, wa, e_wa;
    logic        er, e_er;
    int          lat, nrd, nwr, e_lat, e_nrd, e_nwr;
    int          mism, wr_seen, rv_seen;
    logic [63:0] word;

    for (int i = 0; i < MEM_DEPTH; i++) tb_mem[i] = 64'd0;
    for (int i = 0; i < MEM_DEPTH*8; i++) ref_mem[i] = 8'd0;

    vecs[0]  = '{1'b1, 2'd3, 1'b0, 64'h10,  64'h1122334455667788, 0, 64'h0,                 1'b0, 2, 0, 1, 64'h1122334455667788};
    vecs[1]  = '{1'b0, 2'd3, 1'b0, 64'h10,  64'h0,                3, 64'h1122334455667788,  1'b0, 2, 1, 0, 64'h1122334455667788};
    vecs[2]  = '{1'b1, 2'd0, 1'b0, 64'h13,  64'hDEADBEEFCAFE12AB, 1, 64'h0,                 1'b0, 3, 1, 1, 64'h11223344AB667788};
    vecs[3]  = '{1'b0, 2'd0, 1'b0, 64'h13,  64'h0,                0, 64'hFFFFFFFFFFFFFFAB,  1'b0, 2, 1, 0, 64'h11223344AB667788};
    vecs[4]  = '{1'b0, 2'd0, 1'b1, 64'h13,  64'h0,                0, 64'h00000000000000AB,  1'b0, 2, 1, 0, 64'h11223344AB667788};
    vecs[5]  = '{1'b0, 2'd2, 1'b0, 64'h200, 64'h0,                2, 64'h0,                 1'b1, 1, 0, 0, 64'h11223344AB667788};
`ifdef LSU_MISALIGN_TRAP_EN
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 64'h11,  64'h0,                0, 64'h0,                 1'b1, 1, 0, 0, 64'h11223344AB667788};
`else
    vecs[6]  = '{1'b0, 2'd1, 1'b0, 64'h11,  64'h0,                0, 64'h0000000000007788,  1'b0, 2, 1, 0, 64'h11223344AB667788};
`endif
    vecs[7]  = '{1'b1, 2'd1, 1'b0, 64'h16,  64'h000000001234BEEF, 0, 64'h0,                 1'b0, 3, 1, 1, 64'hBEEF3344AB667788};
    vecs[8]  = '{1'b0, 2'd1, 1'b0, 64'h16,  64'h0,                0, 64'hFFFFFFFFFFFFBEEF,  1'b0, 2, 1, 0, 64'hBEEF3344AB667788};
    vecs[9]  = '{1'b0, 2'd2, 1'b1, 64'h14,  64'h0,                0, 64'h00000000BEEF3344,  1'b0, 2, 1, 0, 64'hBEEF3344AB667788};
    vecs[10] = '{1'b0, 2'd2, 1'b0, 64'h14,  64'h0,                0, 64'hFFFFFFFFBEEF3344,  1'b0, 2, 1, 0, 64'hBEEF3344AB667788};
    vecs[11] = '{1'b1, 2'd2, 1'b0, 64'h208, 64'h00000000FFFFFFFF, 0, 64'h0,                 1'b1, 1, 0, 0, 64'hBEEF3344AB667788};
    vecs[12] = '{1'b0, 2'd3, 1'b0, 64'h1F8, 64'h0,                0, 64'h0,                 1'b0, 2, 1, 0, 64'hBEEF3344AB667788};

    // Reset state
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'd0; req_wdata = 64'd0; resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", {63'd0, req_ready}, 64'd1);
    check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", {63'd0, resp_err}, 64'd0);
    check("rst_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);

    // Directed vector table
    for (int i = 0; i < 13; i++) begin
      ref_access(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                 e_rd, e_er, e_lat, e_nrd, e_nwr, e_wa);
      do_txn(vecs[i].we, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd, vecs[i].hold,
             rd, er, lat, nrd, nwr, wa);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("v%0d_err", i), {63'd0, er}, {63'd0, vecs[i].exp_err});
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("v%0d_reads", i), 64'(nrd), 64'(vecs[i].exp_nrd));
      check($sformatf("v%0d_writes", i), 64'(nwr), 64'(vecs[i].exp_nwr));
      if (vecs[i].exp_nwr != 0) check($sformatf("v%0d_waddr", i), wa, 64'd2);
      check($sformatf("v%0d_word2", i), tb_mem[2], vecs[i].exp_w2);
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      logic        we, uns;
      logic [1:0]  sz;
      logic [63:0] addr, wd;
      we   = 1'($urandom);
      sz   = 2'($urandom);
      uns  = 1'($urandom);
      addr = {53'd0, 8'($urandom_range(0, 71)), 3'($urandom)};
      if ($urandom_range(0, 19) == 0) addr[63:40] = 24'($urandom) | 24'd1;
      wd   = {$urandom, $urandom};
      ref_access(we, sz, uns, addr, wd, e_rd, e_er, e_lat, e_nrd, e_nwr, e_wa);
      do_txn(we, sz, uns, addr, wd, $urandom_range(0, 2), rd, er, lat, nrd, nwr, wa);
      check($sformatf("r%0d_rdata", n), rd, e_rd);
      check($sformatf("r%0d_err", n), {63'd0, er}, {63'd0, e_er});
      check($sformatf("r%0d_latency", n), 64'(lat), 64'(e_lat));
      check($sformatf("r%0d_reads", n), 64'(nrd), 64'(e_nrd));
      check($sformatf("r%0d_writes", n), 64'(nwr), 64'(e_nwr));
      if (e_nwr != 0) check($sformatf("r%0d_waddr", n), wa, e_wa);
    end

    // Whole-memory comparison against the reference bytes
    mism = 0;
    for (int w = 0; w < MEM_DEPTH; w++) begin
      for (int b = 0; b < 8; b++) word[8*b +: 8] = ref_mem[w*8 + b];
      if (tb_mem[w] !== word) mism++;
    end
    check("mem_final_mismatches", 64'(mism), 64'd0);
    check("protocol_violations", 64'(proto_err), 64'd0);

    // Reset asserted during WRITE of a double store
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 64'h30; req_wdata = 64'hA5A5A5A5A5A5A5A5;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("rstw_in_write", {63'd0, mem_write}, 64'd1);
    rst_n = 1'b0;
    wr_seen = 0; rv_seen = 0;
    #1;
    if (mem_write) wr_seen++;
    repeat (2) begin
      @(negedge clk);
      if (mem_write) wr_seen++;
      if (resp_valid) rv_seen++;
    end
    rst_n = 1'b1;
    #1;
    check("rstw_req_ready", {63'd0, req_ready}, 64'd1);
    check("rstw_resp_valid", {63'd0, resp_valid}, 64'd0);
    check("rstw_resp_rdata", resp_rdata, 64'd0);
    check("rstw_resp_err", {63'd0, resp_err}, 64'd0);
    check("rstw_mem_strobes", {62'd0, mem_read, mem_write}, 64'd0);
    repeat (4) begin
      @(negedge clk);
      if (mem_write) wr_seen++;
      if (resp_valid) rv_seen++;
    end
    check("rstw_no_write_pulse", 64'(wr_seen), 64'd0);
    check("rstw_no_response", 64'(rv_seen), 64'd0);

    // Unit still works after the abandoned transaction
    ref_access(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, e_rd, e_er, e_lat, e_nrd, e_nwr, e_wa);
    do_txn(1'b0, 2'd3, 1'b0, 64'h10, 64'h0, 0, rd, er, lat, nrd, nwr, wa);
    check("post_rst_load", rd, e_rd);
    check("post_rst_latency", 64'(lat), 64'(e_lat));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 64, meaning the number of 64-bit doublewords in the attached data memory.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous to clk, active-low.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size  input  2  size: 00 = byte, 01 = half, 10 = word, 11 = double.
REQ-008 SHALL have port req_unsigned  input  1  zero-extend the load result (1) or sign-extend it (0).
REQ-009 SHALL have port req_addr  input  64  byte address.
REQ-010 SHALL have port req_wdata  input  64  store data, right-justified.
REQ-011 SHALL have port resp_valid  output  1  response present.
REQ-012 SHALL have port resp_ready  input  1  consumer accepts the response.
REQ-013 SHALL have port resp_rdata  output  64  extended load data; 0 for stores.
REQ-014 SHALL have port resp_err  output  1  access fault.
REQ-015 SHALL have ports mem_read, mem_write (output 1), mem_addr, mem_wdata (output 64) and mem_rdata (input 64), which drive the data memory's MemRead, MemWrite, addr and write_data, and take its read_data.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, WRITE, RESP.
- req_ready = 1 only in IDLE.
- A request is accepted on a rising edge where req_valid and req_ready are both 1.
- The accepted request is latched; later changes on req_* have no effect.
REQ-017 SHALL set mem_addr = latched addr[63:3] zero-extended to 64 bits (doubleword index); byte offset = addr[2:0]; lane order little-endian.
REQ-018 SHALL, on an accepted load, enter ACCESS.
- ACCESS: mem_read = 1 and mem_rdata is sampled.
- Next state RESP, with resp_rdata = the selected lanes, sign- or zero-extended to 64 bits.
- Load latency: resp_valid is asserted 2 cycles after the accept edge.
REQ-019 SHALL, on an accepted store with size 11, go directly to WRITE.
- WRITE: mem_write = 1 and mem_wdata = req_wdata, for exactly one cycle.
- Next state RESP.
REQ-020 SHALL, on an accepted store with size below 11, perform read-modify-write.
- ACCESS: mem_read = 1 and mem_rdata is sampled.
- WRITE: mem_wdata = sampled word with only the addressed bytes replaced by req_wdata's low bytes.
- Next state RESP.
REQ-021 SHALL, in RESP, hold resp_valid = 1 and resp_rdata/resp_err stable until resp_ready = 1, then return to IDLE on that edge.
- A new request is not accepted in the same edge.
REQ-022 SHALL, when addr[63:3] is at or above MEM_DEPTH, go directly from IDLE to RESP with resp_err = 1 and resp_rdata = 0, and assert no mem strobe.
REQ-023 SHALL never assert mem_read and mem_write in the same cycle; both SHALL be 0 in IDLE and RESP.
REQ-024 SHALL drive mem_wdata = 0 whenever mem_write = 0.

Reset
REQ-025 SHALL, while rst_n = 0 at a rising edge, enter IDLE and clear all latched request fields and the response registers.
REQ-026 SHALL, after reset, drive req_ready = 1, resp_valid = 0, resp_rdata = 0, resp_err = 0, and mem_read = mem_write = 0.
REQ-027 SHALL, when reset occurs mid-operation (including during WRITE), abandon the transaction with no further mem_write pulse and no response.

Configuration
REQ-028 SHALL provide macro LSU_MISALIGN_TRAP_EN to control handling of misaligned addresses (addr not a multiple of 2^req_size).
- Defined: a misaligned access goes IDLE to RESP with resp_err = 1, resp_rdata = 0, and no mem strobe.
- Undefined: the address low bits are forced to the size alignment (cleared) and the access proceeds normally; resp_err is then set only by REQ-022.

Verification
REQ-029 SHALL cover: store double 0x1122334455667788 to addr 0x10, then load double from 0x10 -> resp_rdata = 0x1122334455667788; mem_addr = 2; WRITE lasts one cycle.
REQ-030 SHALL cover: with word 2 preset as in REQ-029, store byte 0xAB to addr 0x13 -> memory word 2 = 0x11223344AB667788; read-modify-write sequence is ACCESS, WRITE, RESP.
REQ-031 SHALL cover: load byte from 0x13 signed -> 0xFFFFFFFFFFFFFFAB; unsigned -> 0x00000000000000AB; resp_valid arrives 2 cycles after the accept.
REQ-032 SHALL cover: load word from addr 0x200 (index 64) -> resp_err = 1, resp_rdata = 0, no mem_read pulse.
REQ-033 SHALL cover: load half from 0x11 -> with the macro, resp_err = 1; without it, the load returns the half at 0x10 with resp_err = 0.
REQ-034 SHALL cover: hold resp_ready = 0 for 3 cycles in RESP -> resp_valid and data stay stable and req_ready = 0; also drive rst_n low during WRITE -> no mem_write pulse follows and req_ready = 1 after reset.
